// File: rtl/snake_game_if.sv
// Handshake and status bundle between the snake game sequencer and its surroundings.
// master: the sequencer side; slave: debouncers, snake_body and display side.
interface snake_game_if #(
  parameter int unsigned H_LOGIC_WIDTH = 5,
  parameter int unsigned V_LOGIC_WIDTH = 5
);
  logic                     btn_start;
  logic                     btn_pause;
  logic [1:0]               key_dir;
  logic                     key_vld;
  logic                     snake_score;
  logic                     collide;
  logic                     body_rst;
  logic                     body_enb;
  logic                     body_valid;
  logic [1:0]               body_dir;
  logic [H_LOGIC_WIDTH-1:0] preyx;
  logic [V_LOGIC_WIDTH-1:0] preyy;
  logic [7:0]               score;
  logic [1:0]               game_state;

  modport master (
    input  btn_start, btn_pause, key_dir, key_vld, snake_score, collide,
    output body_rst, body_enb, body_valid, body_dir, preyx, preyy, score, game_state
  );

  modport slave (
    output btn_start, btn_pause, key_dir, key_vld, snake_score, collide,
    input  body_rst, body_enb, body_valid, body_dir, preyx, preyy, score, game_state
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: start/play/pause/over FSM, move strobe, direction filter, prey and score.
// Optional SNAKE_SPEEDUP_EN shortens the move period as the score grows.
module snake_game_ctrl #(
  parameter int unsigned TICK_PERIOD   = 25_000_000,
  parameter int unsigned TICK_WIDTH    = 25,
  parameter int unsigned INIT_CYCLES   = 4,
  parameter logic [7:0]  SCORE_MAX     = 8'd125,
  parameter int unsigned H_LOGIC_WIDTH = 5,
  parameter int unsigned V_LOGIC_WIDTH = 5,
  parameter int unsigned H_LOGIC_MAX   = 31,
  parameter int unsigned V_LOGIC_MAX   = 23
`ifdef SNAKE_SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_STEP  = 500_000,
  parameter int unsigned TICK_MIN      = 5_000_000
`endif
) (
  input logic              clk,
  input logic              rst,
  snake_game_if.master     bus_io
);

  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [1:0]  DirRight = 2'b01;

  typedef enum logic [2:0] {StIdle, StInit, StPlay, StPause, StOver} state_e;

  state_e                   state_q, state_d;
  logic [TICK_WIDTH-1:0]    tick_q, tick_d, period;
  logic [InitW-1:0]         init_q, init_d;
  logic                     restart_q, restart_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [1:0]               pending_q, pending_d, dir_q, dir_d;
  logic [7:0]               score_q, score_d;
  logic [H_LOGIC_WIDTH-1:0] preyx_q, preyx_d;
  logic [V_LOGIC_WIDTH-1:0] preyy_q, preyy_d, prey_row;
  logic                     body_rst_q, body_rst_d, body_enb_q, body_enb_d;
  logic                     body_valid_q, body_valid_d;
  logic [1:0]               gstate_q, gstate_d;

`ifdef SNAKE_SPEEDUP_EN
  logic [TICK_WIDTH-1:0] period_q, period_d, period_next;
  logic [31:0]           spd_prod;
  assign spd_prod    = 32'(score_q) * SPEEDUP_STEP;
  assign period_next = (spd_prod + TICK_MIN >= TICK_PERIOD) ? TICK_WIDTH'(TICK_MIN)
                                                             : TICK_WIDTH'(TICK_PERIOD - spd_prod);
  assign period      = period_q;
`else
  assign period = TICK_WIDTH'(TICK_PERIOD);
`endif

  assign prey_row = lfsr_q[H_LOGIC_WIDTH +: V_LOGIC_WIDTH];

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    init_d       = init_q;
    restart_d    = restart_q;
    pending_d    = pending_q;
    dir_d        = dir_q;
    score_d      = score_q;
    preyx_d      = preyx_q;
    preyy_d      = preyy_q;
    body_valid_d = 1'b0;
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef SNAKE_SPEEDUP_EN
    period_d     = period_q;
`endif

    unique case (state_q)
      StIdle: begin
        // restart_q carries an OVER-state start through the one-cycle body reset
        if (bus_io.btn_start || restart_q) begin
          state_d   = StInit;
          restart_d = 1'b0;
        end
      end
      StInit: begin
        if (init_q == InitW'(INIT_CYCLES - 1)) state_d = StPlay;
        else                                   init_d  = init_q + 1'b1;
      end
      StPlay: begin
        if (bus_io.snake_score) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          preyx_d = H_LOGIC_WIDTH'(32'(lfsr_q[H_LOGIC_WIDTH-1:0]) % (H_LOGIC_MAX + 1));
          preyy_d = (32'(prey_row) > V_LOGIC_MAX) ? prey_row - V_LOGIC_WIDTH'(8) : prey_row;
        end
        if (bus_io.collide || (bus_io.snake_score && score_d >= SCORE_MAX)) state_d = StOver;
        else if (bus_io.btn_pause)                                          state_d = StPause;
        if (bus_io.key_vld && (bus_io.key_dir != ~dir_q)) pending_d = bus_io.key_dir;
        // tick freezes on the cycle the game leaves PLAY so a resume continues where it stopped
        if (state_d == StPlay) begin
          if (tick_q == period - TICK_WIDTH'(1)) begin
            tick_d       = '0;
            body_valid_d = 1'b1;
            dir_d        = pending_d;
`ifdef SNAKE_SPEEDUP_EN
            period_d     = period_next;
`endif
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StPause: begin
        if (bus_io.btn_pause) state_d = StPlay;
      end
      StOver: begin
        if (bus_io.btn_start) begin
          state_d   = StIdle;
          restart_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StInit && state_q != StInit) begin
      init_d    = '0;
      tick_d    = '0;
      score_d   = 8'd0;
      dir_d     = DirRight;
      pending_d = DirRight;
`ifdef SNAKE_SPEEDUP_EN
      period_d  = TICK_WIDTH'(TICK_PERIOD);
`endif
    end

    body_rst_d = (state_d == StIdle);
    body_enb_d = (state_d == StPlay);
    unique case (state_d)
      StPlay:  gstate_d = 2'b01;
      StPause: gstate_d = 2'b10;
      StOver:  gstate_d = 2'b11;
      default: gstate_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      init_q       <= '0;
      restart_q    <= 1'b0;
      lfsr_q       <= 16'hACE1;
      pending_q    <= DirRight;
      dir_q        <= DirRight;
      score_q      <= 8'd0;
      preyx_q      <= H_LOGIC_WIDTH'(20);
      preyy_q      <= V_LOGIC_WIDTH'(11);
      body_rst_q   <= 1'b1;
      body_enb_q   <= 1'b0;
      body_valid_q <= 1'b0;
      gstate_q     <= 2'b00;
`ifdef SNAKE_SPEEDUP_EN
      period_q     <= TICK_WIDTH'(TICK_PERIOD);
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      init_q       <= init_d;
      restart_q    <= restart_d;
      lfsr_q       <= lfsr_d;
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      score_q      <= score_d;
      preyx_q      <= preyx_d;
      preyy_q      <= preyy_d;
      body_rst_q   <= body_rst_d;
      body_enb_q   <= body_enb_d;
      body_valid_q <= body_valid_d;
      gstate_q     <= gstate_d;
`ifdef SNAKE_SPEEDUP_EN
      period_q     <= period_d;
`endif
    end
  end

  assign bus_io.body_rst   = body_rst_q;
  assign bus_io.body_enb   = body_enb_q;
  assign bus_io.body_valid = body_valid_q;
  assign bus_io.body_dir   = dir_q;
  assign bus_io.preyx      = preyx_q;
  assign bus_io.preyy      = preyy_q;
  assign bus_io.score      = score_q;
  assign bus_io.game_state = gstate_q;

endmodule
